// File: rtl/aes_pkg.sv
// Shared AES-128 primitives: S-box, GF(2^8) helpers, round constants and key step.
// Byte i of a 128-bit block sits at bits [127-8i -: 8]; bytes 4c..4c+3 form column c.
package aes_pkg;
  typedef logic [127:0] state_t;
  typedef logic [127:0] key_t;

  localparam int NBYTES = 16;
  localparam int NCOLS  = 4;
  localparam int NROWS  = 4;

  // Entry 0 is the most significant byte, so sbox(b) selects element ~b.
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // Index 1..10 hold the FIPS round constants; everything else reads as zero.
  localparam logic [15:0][7:0] RCON = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h36, 8'h1b, 8'h80,
    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[~b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] get_byte(input state_t s, input int i);
    return s[7'(127 - 8*i) -: 8];
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    state_t o = '0;
    for (int i = 0; i < NBYTES; i++) o[7'(127 - 8*i) -: 8] = sbox(get_byte(s, i));
    return o;
  endfunction

  function automatic state_t shift_rows(input state_t s);
    state_t o = '0;
    for (int c = 0; c < NCOLS; c++)
      for (int r = 0; r < NROWS; r++)
        o[7'(127 - 8*(4*c + r)) -: 8] = get_byte(s, 4*((c + r) % 4) + r);
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t o = '0;
    for (int c = 0; c < NCOLS; c++) o[7'(127 - 32*c) -: 32] = mix_column(s[7'(127 - 32*c) -: 32]);
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic key_t key_expand_step(input key_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES round; 'last' drops MixColumns for the final round.
module aes_round_unit
  import aes_pkg::*;
(
  input  state_t state_in,
  input  key_t   round_key,
  input  logic   last,
  output state_t state_out
);
  state_t sr;

  assign sr        = shift_rows(sub_bytes(state_in));
  assign state_out = (last ? sr : mix_columns(sr)) ^ round_key;
endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: RPC rounds per clock, on-the-fly key schedule,
// valid/ready on both sides.
module aes128_iter_core
  import aes_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  if (RPC != 1 && RPC != 2 && RPC != 5 && RPC != 10) begin : g_bad_rpc
    $error("aes128_iter_core: RPC must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  fsm_t       fsm, fsm_nxt;
  state_t     state_reg;
  key_t       key_reg;
  logic [3:0] rnd;
  logic       accept, last_step;

  logic [RPC:0][127:0] st_chain, key_chain;

  assign st_chain[0]  = state_reg;
  assign key_chain[0] = key_reg;

  // Round g of this clock is round rnd+g; its key is derived from the previous stage's key.
  for (genvar g = 0; g < RPC; g++) begin : g_rnd
    logic [3:0] r;
    assign r              = rnd + 4'(g);
    assign key_chain[g+1] = key_expand_step(key_chain[g], RCON[r]);
    aes_round_unit u_round (
      .state_in  (st_chain[g]),
      .round_key (key_chain[g+1]),
      .last      (r == 4'd10),
      .state_out (st_chain[g+1])
    );
  end

  assign in_ready  = !rst && (fsm == IDLE || (fsm == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign last_step = (rnd + 4'(RPC - 1)) == 4'd10;
  assign out_valid = (fsm == DONE);

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (accept) fsm_nxt = BUSY;
      BUSY:    if (last_step) fsm_nxt = DONE;
      DONE:    if (out_ready) fsm_nxt = accept ? BUSY : IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      rnd       <= '0;
      out_data  <= '0;
    end else begin
      fsm <= fsm_nxt;
      if (accept) begin
        state_reg <= in_data ^ in_key;
        key_reg   <= in_key;
        rnd       <= 4'd1;
      end else if (fsm == BUSY) begin
        state_reg <= st_chain[RPC];
        key_reg   <= key_chain[RPC];
        rnd       <= rnd + 4'(RPC);
        if (last_step) out_data <= st_chain[RPC];
      end
    end
  end
endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed FIPS-197 vectors against four core instances (RPC = 1, 2, 5, 10).
module tb_aes128_iter_core;
  logic         clk = 0;
  logic         rst;
  logic [127:0] in_data, in_key;
  logic         iv   [4];
  logic         ordy [4];
  logic         irdy [4];
  logic         ov   [4];
  logic [127:0] od   [4];

  int errs = 0, checks = 0;
  int rpcv [4] = '{1, 2, 5, 10};

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes128_iter_core #(.RPC(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (irdy[g]),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_data  (od[g])
    );
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_key  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Offer a block and wait for the acceptance edge.
  task automatic start_block(input int d, input vec_t v, input string name);
    int wt = 0;
    in_key = v.key; in_data = v.pt; iv[d] = 1;
    while (!irdy[d] && wt < 30) begin tick(); wt++; end
    chk({name, "_in_ready"}, 128'(irdy[d]), 128'(1));
    tick();
    iv[d] = 0;
  endtask

  // Inputs are scrambled every busy cycle: only acceptance-time values may matter.
  task automatic wait_done(input int d, input vec_t v, input string name);
    int lat = 0;
    while (!ov[d] && lat < 40) begin scramble(); tick(); lat++; end
    chk({name, "_latency"}, 128'(lat), 128'(10 / rpcv[d]));
    chk({name, "_ct"}, od[d], v.ct);
  endtask

  task automatic consume(input int d, input vec_t v, input string name);
    ordy[d] = 1;
    tick();
    ordy[d] = 0;
    chk({name, "_valid_drop"}, 128'(ov[d]), 128'(0));
    chk({name, "_ct_kept"}, od[d], v.ct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic stale;
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    rst = 1; in_data = '0; in_key = '0;
    for (int d = 0; d < 4; d++) begin iv[d] = 0; ordy[d] = 0; end
    tick(); tick();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_in_ready_%0d", d), 128'(irdy[d]), 128'(0));
      chk($sformatf("rst_out_valid_%0d", d), 128'(ov[d]), 128'(0));
      chk($sformatf("rst_out_data_%0d", d), od[d], 128'(0));
    end
    rst = 0;
    #1;
    for (int d = 0; d < 4; d++) chk($sformatf("post_rst_in_ready_%0d", d), 128'(irdy[d]), 128'(1));

    // Vector table on every unroll factor.
    for (int d = 0; d < 4; d++)
      for (int v = 0; v < 2; v++) begin
        string nm;
        nm = $sformatf("rpc%0d_v%0d", rpcv[d], v);
        start_block(d, vecs[v], nm);
        wait_done(d, vecs[v], nm);
        consume(d, vecs[v], nm);
      end

    // Backpressure on RPC=1.
    start_block(0, vecs[0], "bp");
    wait_done(0, vecs[0], "bp");
    for (int i = 0; i < 20; i++) begin
      iv[0] = i[0];
      in_data = vecs[1].pt; in_key = vecs[1].key;
      chk($sformatf("bp_hold_valid_%0d", i), 128'(ov[0]), 128'(1));
      chk($sformatf("bp_hold_data_%0d", i), od[0], vecs[0].ct);
      chk($sformatf("bp_in_ready_%0d", i), 128'(irdy[0]), 128'(0));
      tick();
    end
    iv[0] = 0;
    consume(0, vecs[0], "bp");
    chk("bp_idle_in_ready", 128'(irdy[0]), 128'(1));
    tick(); tick();
    chk("bp_no_extra_block", 128'(ov[0]), 128'(0));

    // Back-to-back: second block accepted on the edge that consumes the first.
    ordy[0] = 1; iv[0] = 1;
    in_key = vecs[0].key; in_data = vecs[0].pt;
    tick();
    in_key = vecs[1].key; in_data = vecs[1].pt;
    lat = 0;
    while (!ov[0] && lat < 40) begin tick(); lat++; end
    chk("b2b_lat0", 128'(lat), 128'(10));
    chk("b2b_ct0", od[0], vecs[0].ct);
    chk("b2b_in_ready_at_done", 128'(irdy[0]), 128'(1));
    tick();
    iv[0] = 0;
    chk("b2b_second_accepted", 128'(irdy[0]), 128'(0));
    chk("b2b_valid_gone", 128'(ov[0]), 128'(0));
    lat = 0;
    while (!ov[0] && lat < 40) begin scramble(); tick(); lat++; end
    chk("b2b_lat1", 128'(lat), 128'(10));
    chk("b2b_ct1", od[0], vecs[1].ct);
    tick();
    ordy[0] = 0;
    chk("b2b_consumed", 128'(ov[0]), 128'(0));

    // Reset at round 5 on RPC=1.
    start_block(0, vecs[0], "mid_rst");
    for (int i = 0; i < 4; i++) begin scramble(); tick(); end
    rst = 1;
    #1;
    chk("mid_rst_in_ready_low", 128'(irdy[0]), 128'(0));
    tick();
    rst = 0;
    #1;
    chk("mid_rst_out_valid", 128'(ov[0]), 128'(0));
    chk("mid_rst_in_ready", 128'(irdy[0]), 128'(1));
    stale = 0;
    for (int i = 0; i < 15; i++) begin tick(); stale |= ov[0]; end
    chk("mid_rst_no_stale", 128'(stale), 128'(0));
    start_block(0, vecs[0], "after_rst");
    wait_done(0, vecs[0], "after_rst");
    consume(0, vecs[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/aes128_iter_core.md
Name: aes128_iter_core

Overview:
- Iterative AES-128 encryption engine; the multi-cycle successor to the single-round combinational datapath.
- Implements full FIPS-197 rounds: SubBytes, ShiftRows, real MixColumns (skipped in round 10), and AddRoundKey.
- Round keys are expanded on the fly, one per round.
- Valid/ready handshake on input and output; a parameter trades area for latency by unrolling rounds per clock.

Parameters:
- RPC, 1, rounds computed per clock. Legal values are 1, 2, 5, 10. Any other value is an elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  plaintext/key pair offered.
- in_ready  output  1  core can accept a block.
- in_data  input  128  plaintext. Byte 0 is in bits [127:120]; column-major FIPS order, so bytes 0..3 form column 0.
- in_key  input  128  cipher key, same byte order.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- out_data  output  128  ciphertext, same byte order.

Behaviour:
- Reset values: in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts. out_valid=0, out_data=0, FSM=IDLE, round counter=0, key register=0.
- Reset mid-operation: the block in flight is discarded and no out_valid is produced.
- FSM states: IDLE, BUSY, DONE.
- Acceptance: occurs on a clock edge where in_valid && in_ready.
  - state_reg <= in_data ^ in_key (initial AddRoundKey).
  - key_reg <= in_key.
  - rnd <= 1.
  - FSM -> BUSY.
- BUSY: each edge applies RPC consecutive rounds, rnd..rnd+RPC-1, to state_reg.
  - Round r uses round key K_r = expand(K_{r-1}, rcon[r]), with rcon = 01,02,04,08,10,20,40,80,1b,36.
  - key_reg <= K_{rnd+RPC-1}; rnd <= rnd+RPC.
  - Round 10 omits MixColumns.
- BUSY exit: after the edge that completes round 10, FSM -> DONE and out_valid=1 with out_data=ciphertext. This is N=10/RPC edges after the acceptance edge (1 and 10 edges for RPC=10 and RPC=1).
- DONE: out_valid and out_data are held stable until out_ready=1.
  - On the out_ready edge: out_valid <= 0 and FSM -> IDLE, unless a new block is accepted on the same edge (FSM -> BUSY).
- in_ready rule (combinational): in_ready = !rst && (FSM==IDLE || (FSM==DONE && out_ready)).
  - No acceptance while BUSY.
  - Back-to-back throughput is one block per N+1 cycles under continuous out_ready.
- in_data and in_key are sampled only at acceptance; later changes have no effect.
- out_data keeps its last ciphertext after consumption; it is not cleared.
- in_valid may drop without acceptance; there is no obligation to hold it.
- MixColumns: GF(2^8) arithmetic with xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0). Per column: s0' = 2s0^3s1^s2^s3, rotated for the other rows.
- Key expansion word: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}, then w_i' = w_i ^ w_{i-1}'.
- The round counter is 4 bits. Its value is never observable on ports.

Decomposition:
- Shared package aes_pkg holds:
  - the S-box constant table and sbox() function;
  - xtime() and mix_column();
  - the RCON array, indexed 1..10;
  - key_expand_step(key, rcon) function;
  - byte-index constants and the state_t/key_t 128-bit types.
- Sub-module aes_round_unit: combinational single round (state, round_key, last) -> state; last suppresses MixColumns. The core instantiates RPC copies in a generate chain, with the key step chained alongside.

Test Plan:
1. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32. out_valid must rise exactly 10/RPC edges after acceptance; run with RPC=1, 2, 5 and 10.
2. FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
3. Backpressure: hold out_ready=0 for 20 cycles after out_valid.
   - out_valid and out_data stay stable.
   - in_ready stays 0.
   - in_valid pulses are not accepted.
   - Raising out_ready consumes exactly one block.
4. Back-to-back: keep in_valid and out_ready high, streaming vectors 1 then 2.
   - The second block is accepted on the same edge the first is consumed.
   - Both ciphertexts are correct and in order.
5. Reset mid-operation: assert rst for 1 cycle at round 5 (RPC=1).
   - Next cycle: out_valid=0, in_ready=1.
   - No stale out_valid ever appears.
   - A subsequent App. B block encrypts correctly.
6. Input stability: change in_data and in_key every cycle while BUSY; the ciphertext must match the values sampled at acceptance.
